// File: rtl/alu_rr_arbiter.sv
// Round-robin arbiter granting one of four requesters ownership of the shared ALU datapath; registered outputs, 1-cycle grant latency.
// Optional ARB_TIMEOUT_EN: forced rotation after HOLD_MAX held cycles when others are waiting, flagged by to_pulse.
module alu_rr_arbiter #(
  parameter int HOLD_MAX = 8
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [3:0] req,
  output logic [3:0] gnt,
  output logic [1:0] gnt_idx,
  output logic       gnt_vld,
  output logic       to_pulse
);

  localparam logic [0:0] ST_IDLE  = 1'b0;
  localparam logic [0:0] ST_GRANT = 1'b1;

  if (HOLD_MAX < 2 || HOLD_MAX > 255) begin : g_bad_hold_max
    $error("alu_rr_arbiter: HOLD_MAX out of range 2..255");
  end

  // Returns {found, index}; searches ptr+1, ptr+2, ptr+3, ptr.
  function automatic logic [2:0] rr_pick(input logic [3:0] mask, input logic [1:0] ptr);
    logic [2:0] res;
    logic [1:0] cand;
    res = 3'b000;
    for (int k = 1; k <= 4; k++) begin
      cand = ptr + 2'(k);
      if (!res[2] && mask[cand]) res = {1'b1, cand};
    end
    return res;
  endfunction

  logic [0:0] r_state;
  logic [1:0] r_ptr;
  logic [3:0] r_gnt;
  logic [1:0] r_gnt_idx;
  logic       r_gnt_vld;
  logic       r_to_pulse;

  logic [0:0] w_nxt_state;
  logic [1:0] w_nxt_idx;
  logic       w_nxt_vld;
  logic       w_nxt_pulse;
  logic       w_new_grant;
  logic [2:0] w_pick;
  logic       w_owner_req;

  assign w_pick      = rr_pick(req, r_ptr);
  assign w_owner_req = req[r_gnt_idx];

`ifdef ARB_TIMEOUT_EN
  logic [7:0] r_hold_cnt;
  logic [7:0] w_nxt_cnt;
  logic [3:0] w_others;
  logic [2:0] w_rot_pick;
  logic       w_expire;

  assign w_others   = req & ~(4'b0001 << r_gnt_idx);
  assign w_rot_pick = rr_pick(w_others, r_ptr);
  // Counter holds (cycles held - 1), so it reaches HOLD_MAX-1 at the owner's last permitted edge.
  assign w_expire   = (r_hold_cnt == 8'(HOLD_MAX - 1));
`endif

  always_comb begin
    w_nxt_state = r_state;
    w_nxt_idx   = r_gnt_idx;
    w_nxt_vld   = r_gnt_vld;
    w_nxt_pulse = 1'b0;
    w_new_grant = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (w_pick[2]) begin
          w_nxt_state = ST_GRANT;
          w_nxt_idx   = w_pick[1:0];
          w_nxt_vld   = 1'b1;
          w_new_grant = 1'b1;
        end
      end
      default: begin
        if (!w_owner_req) begin
          if (w_pick[2]) begin
            w_nxt_idx   = w_pick[1:0];
            w_new_grant = 1'b1;
          end else begin
            w_nxt_state = ST_IDLE;
            w_nxt_vld   = 1'b0;
          end
        end
`ifdef ARB_TIMEOUT_EN
        else if (w_expire && w_rot_pick[2]) begin
          w_nxt_idx   = w_rot_pick[1:0];
          w_new_grant = 1'b1;
          w_nxt_pulse = 1'b1;
        end
`endif
      end
    endcase
  end

`ifdef ARB_TIMEOUT_EN
  // A sole requester that hits the limit simply restarts its count.
  always_comb begin
    w_nxt_cnt = 8'd0;
    if (w_nxt_state == ST_GRANT && !w_new_grant && !w_expire) w_nxt_cnt = r_hold_cnt + 8'd1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_hold_cnt <= 8'd0;
    else        r_hold_cnt <= w_nxt_cnt;
  end
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= ST_IDLE;
      r_ptr      <= 2'b11;
      r_gnt      <= 4'b0000;
      r_gnt_idx  <= 2'b00;
      r_gnt_vld  <= 1'b0;
      r_to_pulse <= 1'b0;
    end else begin
      r_state    <= w_nxt_state;
      r_gnt_idx  <= w_nxt_idx;
      r_gnt_vld  <= w_nxt_vld;
      r_gnt      <= w_nxt_vld ? (4'b0001 << w_nxt_idx) : 4'b0000;
      r_to_pulse <= w_nxt_pulse;
      if (w_new_grant) r_ptr <= w_nxt_idx;
    end
  end

  assign gnt     = r_gnt;
  assign gnt_idx = r_gnt_idx;
  assign gnt_vld = r_gnt_vld;
  assign to_pulse = r_to_pulse;

endmodule

// File: tb/tb_alu_rr_arbiter.sv
// Directed-vector bench for alu_rr_arbiter (HOLD_MAX=4); the timeout section follows ARB_TIMEOUT_EN.
module tb_alu_rr_arbiter;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [3:0] req = 4'b0000;
  logic [3:0] gnt;
  logic [1:0] gnt_idx;
  logic       gnt_vld;
  logic       to_pulse;

  int n_checks = 0;
  int n_fail   = 0;

  alu_rr_arbiter #(.HOLD_MAX(4)) u_dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .req     (req),
    .gnt     (gnt),
    .gnt_idx (gnt_idx),
    .gnt_vld (gnt_vld),
    .to_pulse(to_pulse)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp_v);
    n_checks++;
    if (act !== exp_v) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", tag, act, exp_v);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic expect_grant(input string tag, input logic [3:0] g, input logic [1:0] idx,
                              input logic vld, input logic pls);
    check({tag, ".gnt"}, 32'(gnt), 32'(g));
    check({tag, ".idx"}, 32'(gnt_idx), 32'(idx));
    check({tag, ".vld"}, 32'(gnt_vld), 32'(vld));
    check({tag, ".pulse"}, 32'(to_pulse), 32'(pls));
  endtask

  // Structural invariants checked every cycle away from the active edge.
  always @(negedge clk) begin
    check("onehot0", 32'($onehot0(gnt)), 32'd1);
    if (gnt_vld) check("gnt_vs_idx", 32'(gnt), 32'(4'b0001 << gnt_idx));
    else         check("gnt_zero", 32'(gnt), 32'd0);
  end

  initial begin
    // Reset state
    tick(); tick();
    expect_grant("reset", 4'b0000, 2'd0, 1'b0, 1'b0);

    // All request: 0 wins first (ptr=3), then drop owners in turn
    rst_n = 1'b1;
    req = 4'b1111; tick(); expect_grant("all_first", 4'b0001, 2'd0, 1'b1, 1'b0);
    req = 4'b1110; tick(); expect_grant("drop0",     4'b0010, 2'd1, 1'b1, 1'b0);
    req = 4'b1100; tick(); expect_grant("drop1",     4'b0100, 2'd2, 1'b1, 1'b0);
    req = 4'b1000; tick(); expect_grant("drop2",     4'b1000, 2'd3, 1'b1, 1'b0);
    req = 4'b0000; tick(); expect_grant("to_idle",   4'b0000, 2'd3, 1'b0, 1'b0);

    // Owner 2 with 0 also requesting, then handoff to 0 and idle
    req = 4'b0100; tick(); expect_grant("own2",      4'b0100, 2'd2, 1'b1, 1'b0);
    req = 4'b0101; tick(); expect_grant("own2_hold", 4'b0100, 2'd2, 1'b1, 1'b0);
    req = 4'b0001; tick(); expect_grant("hand_0",    4'b0001, 2'd0, 1'b1, 1'b0);
    req = 4'b0000; tick(); expect_grant("idle_0",    4'b0000, 2'd0, 1'b0, 1'b0);

    // Single-cycle pulse on req[1]
    req = 4'b0010; tick(); expect_grant("pulse1",    4'b0010, 2'd1, 1'b1, 1'b0);
    req = 4'b0000; tick(); expect_grant("pulse1_end", 4'b0000, 2'd1, 1'b0, 1'b0);
    tick();                expect_grant("pulse1_idle", 4'b0000, 2'd1, 1'b0, 1'b0);

    // Owner holds regardless of other requests (3 cycles, below the timeout)
    req = 4'b1000; tick(); expect_grant("own3",      4'b1000, 2'd3, 1'b1, 1'b0);
    req = 4'b1111;
    for (int i = 0; i < 3; i++) begin
      tick(); expect_grant("own3_hold", 4'b1000, 2'd3, 1'b1, 1'b0);
    end
    req = 4'b0000; tick(); expect_grant("own3_rel", 4'b0000, 2'd3, 1'b0, 1'b0);

    // Asynchronous reset mid-grant, then priority restarts from ptr=3
    req = 4'b0100; tick(); expect_grant("pre_rst",   4'b0100, 2'd2, 1'b1, 1'b0);
    rst_n = 1'b0; #1;
    expect_grant("async_rst", 4'b0000, 2'd0, 1'b0, 1'b0);
    req = 4'b1100; tick();
    rst_n = 1'b1;
    tick(); expect_grant("post_rst", 4'b0100, 2'd2, 1'b1, 1'b0);
    req = 4'b0000; tick(); expect_grant("post_rst_idle", 4'b0000, 2'd2, 1'b0, 1'b0);

`ifdef ARB_TIMEOUT_EN
    // ptr=2: 0 wins, holds 4 cycles, then forced rotation to 1
    req = 4'b0011; tick(); expect_grant("to_own0", 4'b0001, 2'd0, 1'b1, 1'b0);
    for (int i = 0; i < 3; i++) begin
      tick(); expect_grant("to_hold0", 4'b0001, 2'd0, 1'b1, 1'b0);
    end
    tick(); expect_grant("to_rotate", 4'b0010, 2'd1, 1'b1, 1'b1);
    tick(); expect_grant("to_after",  4'b0010, 2'd1, 1'b1, 1'b0);
    req = 4'b0001; tick(); expect_grant("to_sole0", 4'b0001, 2'd0, 1'b1, 1'b0);
    for (int i = 0; i < 9; i++) begin
      tick(); expect_grant("to_sole_hold", 4'b0001, 2'd0, 1'b1, 1'b0);
    end
`else
    // Without the timeout an owner keeps the grant indefinitely
    req = 4'b0011; tick(); expect_grant("nt_own0", 4'b0001, 2'd0, 1'b1, 1'b0);
    for (int i = 0; i < 10; i++) begin
      tick(); expect_grant("nt_hold0", 4'b0001, 2'd0, 1'b1, 1'b0);
    end
`endif
    req = 4'b0000; tick(); expect_grant("final_idle", 4'b0000, 2'd0, 1'b0, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/alu_rr_arbiter.md
ALU_RR_ARBITER -- requirements
Module: alu_rr_arbiter

Interface
REQ-001 The block SHALL have parameter HOLD_MAX, default 8, meaning the maximum consecutive grant cycles per owner when ARB_TIMEOUT_EN is defined; legal range 2..255.
REQ-002 The block SHALL have port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-003 The block SHALL have port rst_n, input, 1 bit: asynchronous, active-low reset.
REQ-004 The block SHALL have port req, input, 4 bits: request from requester i on bit i, level-sensitive.
REQ-005 The block SHALL have port gnt, output, 4 bits: one-hot grant to the shared 4-bit ALU datapath; all-zero when no grant.
REQ-006 The block SHALL have port gnt_idx, output, 2 bits: binary index of the current owner; when gnt_vld=1, gnt SHALL equal 4'b0001 << gnt_idx.
REQ-007 The block SHALL have port gnt_vld, output, 1 bit: high when any grant is active.
REQ-008 The block SHALL have port to_pulse, output, 1 bit: one-cycle pulse on forced grant revocation.

Function
REQ-009 The block SHALL implement two states: IDLE (no owner) and GRANT (one owner).
REQ-010 All outputs SHALL be registered; no combinational path from req to gnt, gnt_idx, gnt_vld or to_pulse.
REQ-011 Winner selection SHALL be round-robin: search order ptr+1, ptr+2, ptr+3, ptr (mod 4), where ptr is the index of the last granted requester.
REQ-012 In IDLE with req!=0 at edge n, the block SHALL enter GRANT at edge n with gnt valid in cycle n+1 (one-cycle latency).
REQ-013 In IDLE with req==0, the block SHALL stay in IDLE with gnt=0, gnt_vld=0.
REQ-014 In GRANT, grant SHALL be held unchanged while req[gnt_idx]=1, regardless of other requests.
REQ-015 In GRANT, if req[gnt_idx]=0 at an edge, the block SHALL re-arbitrate at that edge among the remaining req bits: a winner takes gnt in the next cycle with no idle gap; otherwise the block returns to IDLE with gnt=0.
REQ-016 ptr SHALL update to the new owner index on every grant issued, including back-to-back grants.
REQ-017 gnt SHALL never have more than one bit set in any cycle.
REQ-018 gnt_idx SHALL hold its last value while gnt_vld=0.

Reset
REQ-019 While rst_n=0, the block SHALL force state=IDLE, gnt=4'b0000, gnt_idx=2'b00, gnt_vld=0, to_pulse=0, ptr=2'b11, and hold counter=0, so that requester 0 has first priority after reset.
REQ-020 Reset asserted mid-grant SHALL drop gnt immediately (asynchronously); the first grant after release SHALL follow REQ-012 from ptr=3.

Configuration
REQ-021 Macro ARB_TIMEOUT_EN defined: an 8-bit hold counter SHALL count grant cycles of the current owner and clear on every new grant.
- When the owner has held HOLD_MAX cycles and another req bit is set, the grant SHALL rotate to the round-robin winner excluding the owner, and to_pulse=1 in that first new-grant cycle.
- If the owner is the only requester, it SHALL keep the grant, the counter SHALL restart, and to_pulse SHALL stay 0.
REQ-022 Macro ARB_TIMEOUT_EN undefined: no counter SHALL exist, grants SHALL be held indefinitely per REQ-014, and to_pulse SHALL be tied to 0.

Verification
REQ-023 Reset, then req=4'b1111 held -> gnt=0001 one cycle later; then drop each owner in turn -> gnt=0010, 0100, 1000 in consecutive cycles with no gap.
REQ-024 Owner 2 granted, req=4'b0101, drop req[2] -> gnt=0001 next cycle, ptr=0; then drop req[0] -> gnt=0000, gnt_vld=0.
REQ-025 req=4'b0010 single pulse for one cycle -> gnt=0010 for exactly the cycle after, then IDLE.
REQ-026 rst_n low during gnt=0100 -> gnt=0000 within the same cycle; release with req=4'b1100 -> gnt=0100 (ptr reset to 3).
REQ-027 ARB_TIMEOUT_EN, HOLD_MAX=4, req=4'b0011 held -> owner 0 for 4 cycles, then gnt=0010 with to_pulse=1; with req=4'b0001 only -> gnt=0001 persists and to_pulse=0.
REQ-028 All scenarios -> gnt one-hot or zero every cycle, and gnt == 1<<gnt_idx whenever gnt_vld=1.
